// File: rtl/multimode_wave_generator.sv
// multimode_wave_generator
//   Square (programmable duty), sawtooth and triangle generator driven by a
//   prescaled phase accumulator. Scale, duty and mode are double-buffered and
//   take effect only at a phase wrap, or on every clock while the active scale
//   is 0.
//   Optional feature macro: WAVEGEN_SYNC_EN adds a sync_in port. A high sync_in
//   clears the prescaler, divider and phase and forces a shadow load.
module multimode_wave_generator #(
  parameter int DATA_W     = 6,
  parameter int PRESCALE_W = 6,
  parameter int SCALE_W    = 6
) (
  input  logic               sysclk,
  input  logic               sysrst_n,
  input  logic               enable,
  input  logic [SCALE_W-1:0] scale,
  input  logic [DATA_W-1:0]  duty,
  input  logic [1:0]         mode,
`ifdef WAVEGEN_SYNC_EN
  input  logic               sync_in,
`endif
  output logic [DATA_W-1:0]  wave_out,
  output logic               period_start
);

  localparam logic [1:0] MODE_SQUARE   = 2'b00;
  localparam logic [1:0] MODE_SAWTOOTH = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;

  localparam logic [DATA_W-1:0]     PHASE_MAX = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0]     WAVE_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0]     WAVE_ZERO = {DATA_W{1'b0}};
  localparam logic [SCALE_W-1:0]    SCALE_ZERO = {SCALE_W{1'b0}};
  localparam logic [SCALE_W-1:0]    SCALE_ONE  = SCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);
  localparam logic [DATA_W-1:0]     PHASE_ONE  = DATA_W'(1);

  // Waveform sample for a given phase and mode; mode 11 and any unknown mode give 0.
  function automatic logic [DATA_W-1:0] wave_of(input logic [DATA_W-1:0] p,
                                                input logic [1:0]        md,
                                                input logic [DATA_W-1:0] dt);
    logic [DATA_W-1:0] w;
    case (md)
      MODE_SQUARE:   w = (p < dt) ? WAVE_ONES : WAVE_ZERO;
      MODE_SAWTOOTH: w = p;
      MODE_TRIANGLE: begin
        if (p[DATA_W-1] == 1'b0) begin
          w = {p[DATA_W-2:0], 1'b0};
        end else begin
          w = {~p[DATA_W-2:0], 1'b0};
        end
      end
      default:       w = WAVE_ZERO;
    endcase
    return w;
  endfunction

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [SCALE_W-1:0]    div_q, div_d;
  logic [DATA_W-1:0]     phase_q, phase_d;
  logic [SCALE_W-1:0]    act_scale_q, act_scale_d;
  logic [DATA_W-1:0]     act_duty_q, act_duty_d;
  logic [1:0]            act_mode_q, act_mode_d;
  logic [DATA_W-1:0]     wave_q, wave_d;
  logic                  pstart_q, pstart_d;

  logic sync_s;
  logic tick_s;
  logic scale_zero_s;
  logic div_hit_s;
  logic step_s;
  logic wrap_s;
  logic load_s;

`ifdef WAVEGEN_SYNC_EN
  assign sync_s = sync_in;
`else
  assign sync_s = 1'b0;
`endif

  // Tick, step and wrap decode from the current counter state.
  always_comb begin
    tick_s       = &presc_q;
    scale_zero_s = (act_scale_q == SCALE_ZERO);
    div_hit_s    = (div_q == (act_scale_q - SCALE_ONE));
    step_s       = tick_s & ~scale_zero_s & div_hit_s;
    wrap_s       = step_s & (phase_q == PHASE_MAX);
    load_s       = sync_s | wrap_s | scale_zero_s;
  end

  // Next-state for counters, shadow registers and the registered outputs.
  always_comb begin
    presc_d  = presc_q + PRESC_ONE;
    div_d    = div_q;
    phase_d  = phase_q;
    pstart_d = 1'b0;

    if (sync_s) begin
      presc_d  = {PRESCALE_W{1'b0}};
      div_d    = SCALE_ZERO;
      phase_d  = WAVE_ZERO;
      pstart_d = 1'b0;
    end else begin
      if (tick_s && !scale_zero_s) begin
        if (div_hit_s) begin
          div_d = SCALE_ZERO;
        end else begin
          div_d = div_q + SCALE_ONE;
        end
      end else begin
        div_d = div_q;
      end
      if (step_s) begin
        phase_d = phase_q + PHASE_ONE;
      end else begin
        phase_d = phase_q;
      end
      pstart_d = wrap_s;
    end

    if (load_s) begin
      act_scale_d = scale;
      act_duty_d  = duty;
      act_mode_d  = mode;
    end else begin
      act_scale_d = act_scale_q;
      act_duty_d  = act_duty_q;
      act_mode_d  = act_mode_q;
    end

    // The sample follows the phase register, so wave_out trails phase by one clock.
    if (enable) begin
      wave_d = wave_of(phase_q, act_mode_q, act_duty_q);
    end else begin
      wave_d = WAVE_ZERO;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      presc_q     <= {PRESCALE_W{1'b0}};
      div_q       <= SCALE_ZERO;
      phase_q     <= WAVE_ZERO;
      act_scale_q <= SCALE_ZERO;
      act_duty_q  <= WAVE_ZERO;
      act_mode_q  <= 2'b00;
      wave_q      <= WAVE_ZERO;
      pstart_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      act_scale_q <= act_scale_d;
      act_duty_q  <= act_duty_d;
      act_mode_q  <= act_mode_d;
      wave_q      <= wave_d;
      pstart_q    <= pstart_d;
    end
  end

  assign wave_out     = wave_q;
  assign period_start = pstart_q;

endmodule

// File: tb/tb_multimode_wave_generator.sv
// Testbench for multimode_wave_generator (DATA_W=6, PRESCALE_W=2, SCALE_W=6).
// Compares every clock against a clock-counting reference model.
module tb_multimode_wave_generator;

  localparam int DW = 6;
  localparam int PW = 2;
  localparam int SW = 6;
  localparam int PMOD = 1 << PW;   // clocks per tick
  localparam int NPH  = 1 << DW;   // phases per period

  logic          sysclk = 1'b0;
  logic          sysrst_n;
  logic          enable;
  logic [SW-1:0] scale;
  logic [DW-1:0] duty;
  logic [1:0]    mode;
`ifdef WAVEGEN_SYNC_EN
  logic          sync_in;
`endif
  logic [DW-1:0] wave_out;
  logic          period_start;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers).
  int m_clks;      // clocks since last prescaler clear
  int m_ticks;     // ticks accumulated toward the next phase step
  int m_phase;
  int a_scale, a_duty, a_mode;
  int e_wave, e_ps;

  multimode_wave_generator #(.DATA_W(DW), .PRESCALE_W(PW), .SCALE_W(SW)) dut (
    .sysclk       (sysclk),
    .sysrst_n     (sysrst_n),
    .enable       (enable),
    .scale        (scale),
    .duty         (duty),
    .mode         (mode),
`ifdef WAVEGEN_SYNC_EN
    .sync_in      (sync_in),
`endif
    .wave_out     (wave_out),
    .period_start (period_start)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_wave(input int p, input int md, input int dt);
    case (md)
      0:       return (p < dt) ? NPH - 1 : 0;
      1:       return p;
      2:       return (p < NPH / 2) ? 2 * p : 2 * (NPH - 1 - p);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_clks = 0; m_ticks = 0; m_phase = 0;
    a_scale = 0; a_duty = 0; a_mode = 0;
    e_wave = 0; e_ps = 0;
  endtask

  // One rising edge of the reference: sample from the pre-edge state, then advance.
  task automatic model_clock();
    int s;
    bit tick, step, wrap;
    s = 0;
`ifdef WAVEGEN_SYNC_EN
    s = int'(sync_in);
`endif
    if (!sysrst_n) begin
      model_reset();
    end else begin
      e_wave = enable ? ref_wave(m_phase, a_mode, a_duty) : 0;
      tick = ((m_clks % PMOD) == PMOD - 1);
      step = tick && (a_scale != 0) && (m_ticks + 1 == a_scale);
      wrap = step && (m_phase == NPH - 1);
      if (s != 0) begin
        m_clks = 0; m_ticks = 0; m_phase = 0; e_ps = 0;
      end else begin
        m_clks++;
        if (tick && a_scale != 0) m_ticks = step ? 0 : m_ticks + 1;
        if (step) m_phase = (m_phase + 1) % NPH;
        e_ps = wrap ? 1 : 0;
      end
      if (s != 0 || wrap || a_scale == 0) begin
        a_scale = int'(scale); a_duty = int'(duty); a_mode = int'(mode);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk);
      model_clock();
      @(negedge sysclk);
      check_eq("wave_out", int'(wave_out), e_wave);
      check_eq("period_start", int'(period_start), e_ps);
    end
  endtask

  // Advance until the model reaches a phase, bounded.
  task automatic run_to_phase(input int ph, input string tag);
    int k;
    k = 0;
    while (m_phase != ph && k < 20000) begin
      run(1);
      k++;
    end
    check_eq(tag, m_phase, ph);
  endtask

  int ps_cnt;

  initial begin
    sysrst_n = 1'b0; enable = 1'b0; scale = '0; duty = '0; mode = 2'b00;
`ifdef WAVEGEN_SYNC_EN
    sync_in = 1'b0;
`endif
    model_reset();
    @(negedge sysclk);
    @(negedge sysclk);
    check_eq("rst_wave", int'(wave_out), 0);
    check_eq("rst_ps", int'(period_start), 0);

    // Sawtooth, one step per tick.
    scale = SW'(1); mode = 2'b01; enable = 1'b1;
    sysrst_n = 1'b1;
    ps_cnt = 0;
    for (int i = 0; i < 520; i++) begin
      run(1);
      ps_cnt += int'(period_start);
    end
    check_eq("saw_ps_count", ps_cnt, 2);

    // Square with duty 16, then duty 0.
    mode = 2'b00; duty = DW'(16);
    run(600);
    duty = DW'(0);
    run(300);

    // Triangle.
    mode = 2'b10;
    run(560);

    // Mid-period change at phase 20: no effect until wrap.
    mode = 2'b01; scale = SW'(1);
    run_to_phase(0, "reach_ph0");
    run_to_phase(20, "reach_ph20");
    scale = SW'(3); mode = 2'b00; duty = DW'(40);
    run(900);

    // Enable low for 10 clocks mid-period.
    run_to_phase(30, "reach_ph30");
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(50);

    // Freeze with scale 0, then restart with scale 2.
    scale = SW'(0);
    run_to_phase(0, "reach_wrap_frz");
    run(100);
    scale = SW'(2); mode = 2'b10;
    run(700);

`ifdef WAVEGEN_SYNC_EN
    scale = SW'(1); mode = 2'b01;
    run_to_phase(40, "reach_ph40");
    sync_in = 1'b1;
    run(1);
    sync_in = 1'b0;
    check_eq("sync_phase", m_phase, 0);
    run(300);
`endif

    // Randomized segments.
    for (int seg = 0; seg < 24; seg++) begin
      mode   = 2'($urandom_range(0, 3));
      duty   = DW'($urandom_range(0, NPH - 1));
      scale  = SW'($urandom_range(0, 3));
      enable = 1'($urandom_range(0, 3) != 0);
`ifdef WAVEGEN_SYNC_EN
      sync_in = 1'($urandom_range(0, 7) == 0);
      run(1);
      sync_in = 1'b0;
`endif
      run($urandom_range(40, 400));
    end

    // Asynchronous reset mid-run clears outputs at once.
    scale = SW'(1); mode = 2'b01; enable = 1'b1;
    run_to_phase(45, "reach_ph45");
    run(2);
    sysrst_n = 1'b0;
    #1;
    check_eq("async_rst_wave", int'(wave_out), 0);
    check_eq("async_rst_ps", int'(period_start), 0);
    model_reset();
    run(3);
    sysrst_n = 1'b1;
    run(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
